// File: rtl/wishbone_pkg.sv
// Shared types and widths for the Wishbone interconnect blocks.
package wishbone_pkg;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic {IDLE, BUSY} wb_arb_state_t;
endpackage

// File: rtl/wishbone_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after 'start', with wrap.
module rr_picker
  import wishbone_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  pick,
  output logic          found
);

  // Walk distances from 'start' outward; the first hit wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int d = 0; d < N; d++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] && (j == ((int'(start) + d) % N))) begin
          pick[j] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave bus among N_MASTER masters,
// with a stall watchdog that answers a silent slave with err.
module wishbone_arbiter
  import wishbone_pkg::*;
#(
  parameter int N_MASTER = 2,
  parameter int TAGSIZE  = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [N_MASTER-1:0]          m_cyc_i,
  input  logic [N_MASTER-1:0]          m_stb_i,
  input  logic [N_MASTER-1:0]          m_we_i,
  input  logic [N_MASTER-1:0]          m_lock_i,
  input  logic [N_MASTER*DATA_W-1:0]   m_adr_i,
  input  logic [N_MASTER*DATA_W-1:0]   m_dat_i,
  input  logic [N_MASTER*SEL_W-1:0]    m_sel_i,
  input  logic [N_MASTER*TAGSIZE-1:0]  m_tga_i,
  input  logic [N_MASTER*TAGSIZE-1:0]  m_tgd_i,
  input  logic [N_MASTER*TAGSIZE-1:0]  m_tgc_i,
  output logic [DATA_W-1:0]            m_dat_o,
  output logic [TAGSIZE-1:0]           m_tgd_o,
  output logic [N_MASTER-1:0]          m_ack_o,
  output logic [N_MASTER-1:0]          m_err_o,
  output logic [N_MASTER-1:0]          m_rty_o,
  output logic [N_MASTER-1:0]          m_gnt_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic                         s_lock_o,
  output logic [DATA_W-1:0]            s_adr_o,
  output logic [DATA_W-1:0]            s_dat_o,
  output logic [SEL_W-1:0]             s_sel_o,
  output logic [TAGSIZE-1:0]           s_tga_o,
  output logic [TAGSIZE-1:0]           s_tgd_o,
  output logic [TAGSIZE-1:0]           s_tgc_o,
  input  logic [DATA_W-1:0]            s_dat_i,
  input  logic [TAGSIZE-1:0]           s_tgd_i,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  input  logic                         s_rty_i
);

  localparam int IW   = $clog2(N_MASTER);
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  wb_arb_state_t       state_q, state_d;
  logic [N_MASTER-1:0] gnt_q, gnt_d;
  logic [IW-1:0]       last_q, last_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  logic [N_MASTER-1:0] pick_req, pick;
  logic                pick_found;
  logic [IW-1:0]       pick_idx, start_idx;
  logic                stb_g, cyc_g, lock_g, wd_fire, slv_resp;

  // The current owner is excluded from the search so a releasing master
  // never re-wins its own handover.
  assign pick_req  = (state_q == BUSY) ? (m_cyc_i & ~gnt_q) : m_cyc_i;
  assign start_idx = (last_q == IW'(N_MASTER - 1)) ? '0 : last_q + 1'b1;
  assign slv_resp  = s_ack_i | s_err_i | s_rty_i;
  assign m_gnt_o   = gnt_q;

  rr_picker #(
    .N  (N_MASTER),
    .IW (IW)
  ) u_picker (
    .req   (pick_req),
    .start (start_idx),
    .pick  (pick),
    .found (pick_found)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      if (pick[k]) pick_idx = IW'(k);
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    wd_d     = '0;
    wd_fire  = 1'b0;
    stb_g    = 1'b0;
    cyc_g    = 1'b0;
    lock_g   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_lock_o = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_tga_o  = '0;
    s_tgd_o  = '0;
    s_tgc_o  = '0;
    m_dat_o  = '0;
    m_tgd_o  = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    m_rty_o  = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = pick;
          last_d  = pick_idx;
          state_d = BUSY;
        end
      end

      BUSY: begin
        for (int k = 0; k < N_MASTER; k++) begin
          if (gnt_q[k]) begin
            cyc_g    = m_cyc_i[k];
            stb_g    = m_stb_i[k];
            lock_g   = m_lock_i[k];
            s_we_o   = m_we_i[k];
            s_adr_o  = m_adr_i[k*DATA_W +: DATA_W];
            s_dat_o  = m_dat_i[k*DATA_W +: DATA_W];
            s_sel_o  = m_sel_i[k*SEL_W +: SEL_W];
            s_tga_o  = m_tga_i[k*TAGSIZE +: TAGSIZE];
            s_tgd_o  = m_tgd_i[k*TAGSIZE +: TAGSIZE];
            s_tgc_o  = m_tgc_i[k*TAGSIZE +: TAGSIZE];
          end
        end
        wd_fire  = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT));
        s_cyc_o  = cyc_g;
        s_lock_o = lock_g;
        // A watchdog error suppresses the strobe and discards any slave answer.
        s_stb_o  = stb_g & ~wd_fire;
        m_dat_o  = s_dat_i;
        m_tgd_o  = s_tgd_i;
        m_ack_o  = gnt_q & {N_MASTER{s_ack_i & ~wd_fire}};
        m_err_o  = gnt_q & {N_MASTER{s_err_i | wd_fire}};
        m_rty_o  = gnt_q & {N_MASTER{s_rty_i & ~wd_fire}};

        if (!cyc_g && !lock_g) begin
          if (pick_found) begin
            gnt_d  = pick;
            last_d = pick_idx;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if ((TIMEOUT != 0) && !wd_fire && stb_g && !slv_resp) begin
          wd_d = wd_q + 1'b1;
        end
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(N_MASTER - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Randomized and directed checks of wishbone_arbiter against an ownership-level reference model.
module tb_wishbone_arbiter;
  localparam int N  = 2;
  localparam int TW = 2;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn;
  logic [N-1:0]    m_cyc, m_stb, m_we, m_lock;
  logic [N*32-1:0] m_adr, m_dat;
  logic [N*4-1:0]  m_sel;
  logic [N*TW-1:0] m_tga, m_tgd, m_tgc;
  logic [31:0]     m_dat_o;
  logic [TW-1:0]   m_tgd_o;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o, m_gnt_o;
  logic            s_cyc_o, s_stb_o, s_we_o, s_lock_o;
  logic [31:0]     s_adr_o, s_dat_o;
  logic [3:0]      s_sel_o;
  logic [TW-1:0]   s_tga_o, s_tgd_o, s_tgc_o;
  logic [31:0]     s_dat;
  logic [TW-1:0]   s_tgd;
  logic            s_ack, s_err, s_rty;

  wishbone_arbiter #(.N_MASTER(N), .TAGSIZE(TW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_lock_i(m_lock),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_tga_i(m_tga), .m_tgd_i(m_tgd), .m_tgc_i(m_tgc),
    .m_dat_o(m_dat_o), .m_tgd_o(m_tgd_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_gnt_o(m_gnt_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_lock_o(s_lock_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_tga_o(s_tga_o), .s_tgd_o(s_tgd_o), .s_tgc_o(s_tgc_o),
    .s_dat_i(s_dat), .s_tgd_i(s_tgd),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: current owner (-1 when the bus is free), last winner, stall count.
  int own  = -1;
  int last = N - 1;
  int wd   = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic idle_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_lock = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    m_tga = '0; m_tgd = '0; m_tgc = '0;
    s_dat = '0; s_tgd = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  task automatic model_reset();
    own = -1; last = N - 1; wd = 0;
  endtask

  // Called at a falling edge with inputs already set; compares, then advances one cycle.
  task automatic tick();
    logic [N-1:0] e_gnt, e_ack, e_err, e_rty;
    logic [77:0]  e_bus, a_bus;
    logic [33:0]  e_rd;
    bit           fire;
    int           nown, nlast, nwd, c;
    #1;
    e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0; e_bus = '0; e_rd = '0; fire = 0;
    if (own >= 0) begin
      fire = (TO != 0) && (wd == TO);
      e_gnt[own] = 1'b1;
      e_bus = {m_cyc[own], m_stb[own] && !fire, m_we[own], m_lock[own],
               m_adr[own*32 +: 32], m_dat[own*32 +: 32], m_sel[own*4 +: 4],
               m_tga[own*TW +: TW], m_tgd[own*TW +: TW], m_tgc[own*TW +: TW]};
      e_rd = {s_dat, s_tgd};
      e_ack[own] = s_ack && !fire;
      e_err[own] = s_err || fire;
      e_rty[own] = s_rty && !fire;
    end
    a_bus = {s_cyc_o, s_stb_o, s_we_o, s_lock_o, s_adr_o, s_dat_o, s_sel_o,
             s_tga_o, s_tgd_o, s_tgc_o};
    check("gnt", m_gnt_o, e_gnt);
    check("bus", a_bus, e_bus);
    check("resp", {m_ack_o, m_err_o, m_rty_o}, {e_ack, e_err, e_rty});
    check("rdata", {m_dat_o, m_tgd_o}, e_rd);

    nown = own; nlast = last; nwd = 0;
    if (own < 0) begin
      for (int d = 1; d <= N; d++) begin
        c = (last + d) % N;
        if (nown < 0 && m_cyc[c]) begin nown = c; nlast = c; end
      end
    end else if (!m_cyc[own] && !m_lock[own]) begin
      nown = -1;
      for (int d = 1; d < N; d++) begin
        c = (own + d) % N;
        if (nown < 0 && m_cyc[c]) begin nown = c; nlast = c; end
      end
    end else if (!fire && m_stb[own] && !(s_ack || s_err || s_rty)) begin
      nwd = wd + 1;
    end
    @(posedge clk);
    own = nown; last = nlast; wd = nwd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int  ack_cnt, exp_k, ntx;
  bit  done [N];
  bit  cyc_r [N];
  bit  silent;
  int  r;

  initial begin
    rstn = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", m_gnt_o, 0);
    check("rst_bus", {s_cyc_o, s_stb_o, s_adr_o, m_ack_o, m_err_o}, 0);
    rstn = 1'b1;
    tick();

    // Single master write to 0x100, slave acks on the third strobe cycle.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
    m_adr[31:0] = 32'h100; m_dat[31:0] = $urandom; m_sel[3:0] = 4'hf;
    tick();
    ack_cnt = 0;
    for (int i = 1; i <= 3; i++) begin
      s_ack = (i == 3);
      #1;
      if (i == 1) begin
        check("gnt_latency", m_gnt_o, 2'b01);
        check("s_adr", s_adr_o, 32'h100);
      end
      ack_cnt += int'(m_ack_o[0]);
      tick();
    end
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0;
    #1;
    ack_cnt += int'(m_ack_o[0]);
    check("ack_pulses", ack_cnt, 1);
    tick();
    tick();

    // Contention: both request together after reset.
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    tick();
    for (int i = 0; i < 3; i++) begin
      s_ack = 1'($urandom_range(0, 1));
      #1;
      check("cont_gnt0", m_gnt_o, 2'b01);
      check("cont_noack1", m_ack_o[1], 1'b0);
      tick();
    end
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    tick();
    #1;
    check("cont_gnt1", m_gnt_o, 2'b10);
    tick();
    m_cyc = '0; m_stb = '0;
    tick();
    tick();

    // Fairness: both request continuously, one ack per tenure.
    do_reset();
    exp_k = 0; ntx = 0;
    for (int k = 0; k < N; k++) done[k] = 0;
    for (int cy = 0; cy < 100 && ntx < 8; cy++) begin
      s_ack = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (m_gnt_o[k] && done[k]) begin
          m_cyc[k] = 1'b0; m_stb[k] = 1'b0; done[k] = 0;
        end else begin
          m_cyc[k] = 1'b1; m_stb[k] = 1'b1;
          if (m_gnt_o[k]) s_ack = 1'b1;
        end
      end
      #1;
      for (int k = 0; k < N; k++) begin
        if (m_ack_o[k]) begin
          check("rr_order", k, exp_k);
          exp_k = (exp_k + 1) % N;
          ntx++;
          done[k] = 1;
        end
      end
      tick();
    end
    check("rr_count", ntx, 8);
    idle_inputs();
    tick();
    tick();

    // Lock: master 1 keeps the bus across a cyc-low gap while master 0 waits.
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_lock[1] = 1'b1;
    tick();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; s_ack = 1'b1;
    #1; check("lock_gnt_a", m_gnt_o, 2'b10);
    tick();
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1; check("lock_hold", m_gnt_o, 2'b10);
      tick();
    end
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; s_ack = 1'b1;
    #1; check("lock_gnt_b", m_gnt_o, 2'b10);
    tick();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_lock[1] = 1'b0; s_ack = 1'b0;
    tick();
    #1; check("lock_release", m_gnt_o, 2'b01);
    tick();
    idle_inputs();
    tick();
    tick();

    // Watchdog: silent slave; a late ack in the timeout cycle must be discarded.
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      s_ack = (i == 5);
      #1;
      check("wd_err", m_err_o, (i == 5) ? 2'b01 : 2'b00);
      if (i == 5) begin
        check("wd_ack_drop", m_ack_o, 2'b00);
        check("wd_stb_low", s_stb_o, 1'b0);
      end
      tick();
    end
    s_ack = 1'b0;
    #1; check("wd_gnt_kept", m_gnt_o, 2'b01);
    tick();
    idle_inputs();
    tick();
    tick();

    // Reset mid-BUSY with master 0 last granted; master 0 must win again afterward.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    tick();
    #2 rstn = 1'b0;
    #1;
    check("arst_gnt", m_gnt_o, 2'b00);
    check("arst_cyc", s_cyc_o, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    m_cyc = 2'b11; m_stb = 2'b11;
    tick();
    #1; check("arst_prio", m_gnt_o, 2'b01);
    tick();
    idle_inputs();
    tick();
    tick();

    // Randomized traffic against the model.
    silent = 0;
    for (int k = 0; k < N; k++) cyc_r[k] = 0;
    for (int cy = 0; cy < 500; cy++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) cyc_r[k] = !cyc_r[k];
        m_cyc[k]  = cyc_r[k];
        m_stb[k]  = cyc_r[k] && ($urandom_range(0, 3) != 0);
        m_lock[k] = ($urandom_range(0, 9) == 0);
        m_we[k]   = 1'($urandom_range(0, 1));
      end
      m_adr = {$urandom, $urandom};
      m_dat = {$urandom, $urandom};
      m_sel = 8'($urandom);
      m_tga = 4'($urandom); m_tgd = 4'($urandom); m_tgc = 4'($urandom);
      if ($urandom_range(0, 19) == 0) silent = !silent;
      r = $urandom_range(0, 9);
      s_ack = !silent && (r < 4);
      s_err = !silent && (r == 4);
      s_rty = !silent && (r == 5);
      s_dat = $urandom;
      s_tgd = 2'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter.md
# wishbone_arbiter

- Round-robin bus arbiter that shares one Wishbone slave-side bus between `N_MASTER` `wishbone_master` instances.
- Drives each master's `wb_gnt_i` input.
- Multiplexes the granted master's cycle onto the shared bus and routes slave responses back to that master only.
- Includes a stall watchdog, so a silent slave cannot hang the interconnect.

## Interface
- `N_MASTER`, 2: number of requesting masters, 2..8.
- `TAGSIZE`, 2: tag width, matching the masters.
- `TIMEOUT`, 255: maximum cycles a strobe may wait for ack/err/rty before the arbiter answers with err; 0 disables the watchdog.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rstn_i`  in  1  reset; one clock, asynchronous, active-low.
- `m_cyc_i`  in  N_MASTER  per-master cycle request.
- `m_stb_i`  in  N_MASTER  per-master strobe.
- `m_we_i`  in  N_MASTER  per-master write enable.
- `m_lock_i`  in  N_MASTER  per-master lock (hold bus across cycles).
- `m_adr_i`  in  N_MASTER*32  packed addresses; master k at [32k+31:32k].
- `m_dat_i`  in  N_MASTER*32  packed write data.
- `m_sel_i`  in  N_MASTER*4  packed byte selects.
- `m_tga_i`, `m_tgd_i`, `m_tgc_i`  in  N_MASTER*TAGSIZE  packed tags.
- `m_dat_o`  out  32  read data, broadcast to all masters.
- `m_tgd_o`  out  TAGSIZE  read data tag, broadcast.
- `m_ack_o`, `m_err_o`, `m_rty_o`  out  N_MASTER  responses, one-hot to the granted master.
- `m_gnt_o`  out  N_MASTER  one-hot grant, registered.
- `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_lock_o`  out  1  shared bus control.
- `s_adr_o`  out  32  shared address.
- `s_dat_o`  out  32  shared write data.
- `s_sel_o`  out  4  shared byte select.
- `s_tga_o`, `s_tgd_o`, `s_tgc_o`  out  TAGSIZE  shared tags.
- `s_dat_i`  in  32  slave read data.
- `s_tgd_i`  in  TAGSIZE  slave read data tag.
- `s_ack_i`, `s_err_i`, `s_rty_i`  in  1  slave responses.

## Operation
FSM has two states, IDLE and BUSY. Registers are:
- `gnt_q` (one-hot)
- `last_q` (index of the last granted master)
- `wd_q` (watchdog counter, width clog2(TIMEOUT+1))

IDLE:
- `gnt_q` = 0 and all `s_*` outputs are 0.
- If any `m_cyc_i` is set, pick the first requester scanning from `last_q+1` modulo N_MASTER, upward with wrap.
- Set its bit in `gnt_q`, update `last_q`, go to BUSY.

BUSY, with granted index g:
- `s_*` = master g's signals; `s_cyc_o` = `m_cyc_i[g]`.
- `m_ack_o[g]` / `m_err_o[g]` / `m_rty_o[g]` = slave responses; all other masters' response bits are 0.
- Release when `m_cyc_i[g]`=0 and `m_lock_i[g]`=0.
- On release, re-arbitrate in the same cycle, excluding g:
  - another requester present → grant moves directly to it, stays BUSY;
  - no other requester → IDLE.
- While `m_lock_i[g]`=1, the grant is held even with cyc low.
- Masters without a grant receive no responses. Their requests wait; no request is dropped.

Watchdog, in BUSY with TIMEOUT≠0:
- `wd_q` increments each cycle that `s_stb_o`=1 and no slave response arrives.
- `wd_q` clears on any response or when stb is low.
- When `wd_q`=TIMEOUT, drive `m_err_o[g]`=1 for one cycle, force `s_stb_o`=0 that cycle, clear `wd_q`.

## Timing
- Reset: `gnt_q`=0, `last_q`=N_MASTER-1 (so master 0 wins first), `wd_q`=0, state IDLE. All outputs are 0.
- Grant latency: `m_cyc_i[k]` rising at cycle t with the bus idle → `m_gnt_o[k]`=1 at t+1.
- Handover: granted master drops cyc at t while another is requesting → new grant at t+1, with no idle cycle between.
- Responses are combinational pass-through, zero added latency. Slave `s_ack_i` at t gives `m_ack_o[g]` at t.
- Simultaneous requests are resolved by round-robin order only. With N_MASTER=2 and both requesting continuously, grants alternate per cycle-release.
- A watchdog error takes priority over a slave response in the same cycle; the slave response is discarded.
- Reset mid-transaction: all outputs drop asynchronously and the bus is abandoned; masters must be reset together with the arbiter.

## Structure
- Shared package `wishbone_pkg` holds:
  - the state enum `wb_arb_state_t` {IDLE, BUSY};
  - localparams for data width 32 and sel width 4.
- One sub-module, `rr_picker`. It is combinational: inputs are the request vector and a start index; outputs are a one-hot pick and a found flag.
  - Reused for the IDLE and BUSY handover decisions.

## Test plan
- Single master: N_MASTER=2, master 0 issues a write to 0x100, slave acks at 3rd stb cycle → `m_gnt_o`=01 one cycle after cyc; exactly one `m_ack_o[0]` pulse; `s_adr_o`=0x100.
- Contention: both masters raise cyc in the same cycle after reset → master 0 granted first; master 1 granted the cycle after master 0 drops cyc; `m_ack_o[1]` is never asserted during master 0's tenure.
- Fairness: both masters request continuously, 8 transactions total → grants strictly alternate 0,1,0,1…
- Lock: master 1 holds lock across two cycles with cyc low between them, while master 0 requests → grant stays 10 until lock drops.
- Watchdog: TIMEOUT=4, slave never responds → `m_err_o[g]` pulses after 4 stalled strobe cycles; grant retained until the master drops cyc.
- Reset mid-BUSY: deassert `rstn_i` while granted → `m_gnt_o`=0 and `s_cyc_o`=0 immediately; after release, master 0 has priority again.
